// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-add cell, LSB first, start/done handshake.
// Define SERIAL_ADDER_CIN_EN to add a carry-in port sampled with start.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_CIN_EN
  input  logic             cin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] ps;
  logic             c;
  logic [CW-1:0]    cnt;

  logic             cin0;
  logic             ha1_s;
  logic             ha1_c;
  logic             s;
  logic             ha2_c;
  logic             c_nx;
  logic [WIDTH:0]   ps_wide;
  logic [WIDTH-1:0] ps_nx;
  logic             last;

`ifdef SERIAL_ADDER_CIN_EN
  assign cin0 = cin;
`else
  assign cin0 = 1'b0;
`endif

  // Full adder built from two half-add stages and a carry OR.
  assign ha1_s = a_sh[0] ^ b_sh[0];
  assign ha1_c = a_sh[0] & b_sh[0];
  assign s     = ha1_s ^ c;
  assign ha2_c = ha1_s & c;
  assign c_nx  = ha1_c | ha2_c;

  // Insert the new bit at the MSB; the concat form also works for WIDTH=1.
  assign ps_wide = {s, ps};
  assign ps_nx   = ps_wide[WIDTH:1];
  assign last    = (cnt == CW'(WIDTH - 1));

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      ps    <= '0;
      c     <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            ps    <= '0;
            c     <= cin0;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          ps   <= ps_nx;
          a_sh <= a_sh >> 1;
          b_sh <= b_sh >> 1;
          c    <= c_nx;
          cnt  <= cnt + CW'(1);
          if (last) begin
            sum   <= ps_nx;
            cout  <= c_nx;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
